// File: rtl/phase_sequencer_pkg.sv
// Shared timing definitions for the word/phase sequencer: state set, phase encoding, defaults.
// Purely declarative; no latency, no backpressure.
package phase_sequencer_pkg;

    localparam int BIT_TIMES_DEFAULT = 14;
    localparam int BT_W              = 4;

    typedef enum logic [1:0] {
        ST_HALT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STEP    = 2'd2,
        ST_HOLDING = 2'd3
    } seq_state_e;

    // One-hot so the phase register bits drive PA/PB/PC directly.
    typedef enum logic [2:0] {
        PH_A = 3'b001,
        PH_B = 3'b010,
        PH_C = 3'b100
    } phase_e;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_A:    return PH_B;
            PH_B:    return PH_C;
            default: return PH_A;
        endcase
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control inputs and timing outputs of the phase sequencer; master drives controls, slave is the sequencer.
// Wires only; no latency, no backpressure.
interface phase_sequencer_if;
    import phase_sequencer_pkg::*;

    logic            run_i;
    logic            step_i;
    logic            hold_i;
    logic            cpu_req_i;
    logic            dma_req_i;
    logic [BT_W-1:0] bt_o;
    logic            pa_o;
    logic            pb_o;
    logic            pc_o;
    logic            tbc_o;
    logic            word_end_o;
    logic            gnt_cpu_o;
    logic            gnt_dma_o;
    logic            halted_o;

    modport master (
        output run_i, step_i, hold_i, cpu_req_i, dma_req_i,
        input  bt_o, pa_o, pb_o, pc_o, tbc_o, word_end_o, gnt_cpu_o, gnt_dma_o, halted_o
    );

    modport slave (
        input  run_i, step_i, hold_i, cpu_req_i, dma_req_i,
        output bt_o, pa_o, pb_o, pc_o, tbc_o, word_end_o, gnt_cpu_o, gnt_dma_o, halted_o
    );
endinterface

// File: rtl/phase_sequencer_slot_arbiter.sv
// Memory-slot arbiter: DMA-priority with alternation, decided on the word boundary, grant registered (1 cycle).
// No backpressure; halt clears both grants and suppresses arbitration.
module slot_arbiter (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic boundary_i,
    input  logic halt_i,
    input  logic cpu_req_i,
    input  logic dma_req_i,
    output logic gnt_cpu_o,
    output logic gnt_dma_o
);
    logic gnt_cpu_q, gnt_cpu_d;
    logic gnt_dma_q, gnt_dma_d;
    logic last_dma_q, last_dma_d;
    logic dma_wins;
    logic cpu_wins;

    // last_dma_q remembers the most recent actual owner; idle words leave it unchanged.
    always_comb begin
        dma_wins   = dma_req_i && !(cpu_req_i && last_dma_q);
        cpu_wins   = cpu_req_i && !dma_wins;
        gnt_cpu_d  = gnt_cpu_q;
        gnt_dma_d  = gnt_dma_q;
        last_dma_d = last_dma_q;
        if (halt_i) begin
            gnt_cpu_d = 1'b0;
            gnt_dma_d = 1'b0;
        end else if (boundary_i) begin
            gnt_cpu_d = cpu_wins;
            gnt_dma_d = dma_wins;
            if (cpu_wins || dma_wins) begin
                last_dma_d = dma_wins;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            gnt_cpu_q  <= 1'b0;
            gnt_dma_q  <= 1'b0;
            last_dma_q <= 1'b0;
        end else begin
            gnt_cpu_q  <= gnt_cpu_d;
            gnt_dma_q  <= gnt_dma_d;
            last_dma_q <= last_dma_d;
        end
    end

    assign gnt_cpu_o = gnt_cpu_q;
    assign gnt_dma_o = gnt_dma_q;
endmodule

// File: rtl/phase_sequencer.sv
// Bit-time/phase sequencer with run/step/hold control; word time is PHASES*BIT_TIMES cycles, outputs registered (TBC combinational).
// HOLD stalls on the last bit time of PC until released; no other backpressure.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int BIT_TIMES = BIT_TIMES_DEFAULT,
    parameter int PHASES    = 3
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    phase_sequencer_if.slave bus_io
);
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(BIT_TIMES - 1);
    localparam phase_e          PH_LAST = phase_e'(3'b001 << (PHASES - 1));

    seq_state_e      state_q, state_d;
    logic [BT_W-1:0] bt_q, bt_d;
    phase_e          phase_q, phase_d;
    logic            step_mode_q, step_mode_d;
    logic            word_end_q, word_end_d;
    logic            halted_q;
    logic            last_bt;
    logic            at_word_end;
    logic            boundary;
    logic            tbc;

    always_comb begin
        state_d     = state_q;
        bt_d        = bt_q;
        phase_d     = phase_q;
        step_mode_d = step_mode_q;
        word_end_d  = 1'b0;
        boundary    = 1'b0;
        tbc         = 1'b0;
        last_bt     = (bt_q == BT_LAST);
        at_word_end = last_bt && (phase_q == PH_LAST);

        case (state_q)
            ST_HALT: begin
                bt_d    = '0;
                phase_d = PH_A;
                if (bus_io.run_i) begin
                    state_d     = ST_RUN;
                    step_mode_d = 1'b0;
                end else if (bus_io.step_i) begin
                    state_d     = ST_STEP;
                    step_mode_d = 1'b1;
                end
            end
            ST_RUN, ST_STEP: begin
                if (at_word_end && bus_io.hold_i) begin
                    state_d = ST_HOLDING;
                end else begin
                    tbc = last_bt;
                    if (at_word_end) begin
                        boundary = 1'b1;
                    end else if (last_bt) begin
                        bt_d    = '0;
                        phase_d = next_phase(phase_q);
                    end else begin
                        bt_d = bt_q + 1'b1;
                    end
                end
            end
            ST_HOLDING: begin
                if (!bus_io.hold_i) begin
                    boundary = 1'b1;
                end
            end
            default: state_d = ST_HALT;
        endcase

        // step_mode_q carries the STEP origin through HOLDING so the boundary knows to halt.
        if (boundary) begin
            bt_d       = '0;
            phase_d    = PH_A;
            word_end_d = 1'b1;
            state_d    = (step_mode_q || !bus_io.run_i) ? ST_HALT : ST_RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= ST_HALT;
            bt_q        <= '0;
            phase_q     <= PH_A;
            step_mode_q <= 1'b0;
            word_end_q  <= 1'b0;
            halted_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            bt_q        <= bt_d;
            phase_q     <= phase_d;
            step_mode_q <= step_mode_d;
            word_end_q  <= word_end_d;
            halted_q    <= (state_d == ST_HALT);
        end
    end

    slot_arbiter u_slot_arbiter (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .boundary_i (boundary),
        .halt_i     (state_d == ST_HALT),
        .cpu_req_i  (bus_io.cpu_req_i),
        .dma_req_i  (bus_io.dma_req_i),
        .gnt_cpu_o  (bus_io.gnt_cpu_o),
        .gnt_dma_o  (bus_io.gnt_dma_o)
    );

    assign bus_io.bt_o       = bt_q;
    assign bus_io.pa_o       = phase_q[0];
    assign bus_io.pb_o       = phase_q[1];
    assign bus_io.pc_o       = phase_q[2];
    assign bus_io.tbc_o      = tbc;
    assign bus_io.word_end_o = word_end_q;
    assign bus_io.halted_o   = halted_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: stimulus queues expected TBC/WORD_END events, a negedge monitor checks them.
module tb_phase_sequencer;
    import phase_sequencer_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int   at;
        logic gc;
        logic gd;
    } we_t;

    we_t  we_q[$];
    int   tbc_q[$];
    logic prev_gc = 1'b0;
    logic prev_gd = 1'b0;
    int   s, s2, s3;

    phase_sequencer_if sif();

    phase_sequencer #(.BIT_TIMES(14), .PHASES(3)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus_io (sif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bt"},       32'(sif.bt_o), 0);
        chk({tag, "_pa"},       32'(sif.pa_o), 1);
        chk({tag, "_pb"},       32'(sif.pb_o), 0);
        chk({tag, "_pc"},       32'(sif.pc_o), 0);
        chk({tag, "_tbc"},      32'(sif.tbc_o), 0);
        chk({tag, "_word_end"}, 32'(sif.word_end_o), 0);
        chk({tag, "_gnt_cpu"},  32'(sif.gnt_cpu_o), 0);
        chk({tag, "_gnt_dma"},  32'(sif.gnt_dma_o), 0);
        chk({tag, "_halted"},   32'(sif.halted_o), 1);
    endtask

    task automatic push_we(input int at, input logic gc, input logic gd);
        we_t w;
        w.at = at;
        w.gc = gc;
        w.gd = gd;
        we_q.push_back(w);
    endtask

    // Monitor: the grant checked at WORD_END is the one held during the word that just ended.
    always @(negedge clk) begin
        we_t w;
        int  e;
        if (rstn) begin
            checks++;
            if (sif.gnt_cpu_o && sif.gnt_dma_o) begin
                errors++;
                $display("FAIL grant_exclusive: both grants 1 (cyc %0d)", cyc);
            end
            if (sif.tbc_o) begin
                if (tbc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tbc_unexpected: tbc=1 with none expected (cyc %0d)", cyc);
                end else begin
                    e = tbc_q.pop_front();
                    chk("tbc_cycle", cyc, e);
                end
            end
            if (sif.word_end_o) begin
                if (we_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_end_unexpected: word_end=1 with none expected (cyc %0d)", cyc);
                end else begin
                    w = we_q.pop_front();
                    chk("word_end_cycle", cyc, w.at);
                    chk("word_gnt_cpu", 32'(prev_gc), 32'(w.gc));
                    chk("word_gnt_dma", 32'(prev_gd), 32'(w.gd));
                end
            end
        end
        prev_gc = sif.gnt_cpu_o;
        prev_gd = sif.gnt_dma_o;
    end

    initial begin
        sif.run_i     = 1'b0;
        sif.step_i    = 1'b0;
        sif.hold_i    = 1'b0;
        sif.cpu_req_i = 1'b0;
        sif.dma_req_i = 1'b0;

        to_cyc(3);
        chk_reset_vals("reset");
        rstn = 1'b1;
        to_cyc(5);
        chk("idle_halted", 32'(sif.halted_o), 1);
        chk("idle_bt", 32'(sif.bt_o), 0);

        // Free run with both requesters for six words, RUN dropped at PA bit 3 of word 6.
        sif.run_i     = 1'b1;
        sif.cpu_req_i = 1'b1;
        sif.dma_req_i = 1'b1;
        s = cyc + 1;
        for (int j = 0; j < 18; j++) tbc_q.push_back(s + 13 + 14 * j);
        push_we(s + 42,  1'b0, 1'b0);
        push_we(s + 84,  1'b0, 1'b1);
        push_we(s + 126, 1'b1, 1'b0);
        push_we(s + 168, 1'b0, 1'b1);
        push_we(s + 210, 1'b1, 1'b0);
        push_we(s + 252, 1'b0, 1'b1);
        to_cyc(s);
        chk("run_start_halted", 32'(sif.halted_o), 0);
        chk("run_start_pa", 32'(sif.pa_o), 1);
        to_cyc(s + 14);
        chk("run_pb", 32'(sif.pb_o), 1);
        to_cyc(s + 28);
        chk("run_pc", 32'(sif.pc_o), 1);
        to_cyc(s + 41);
        chk("run_last_bt", 32'(sif.bt_o), 13);
        to_cyc(s + 42);
        chk("word2_gnt_dma", 32'(sif.gnt_dma_o), 1);
        to_cyc(s + 100);
        sif.step_i = 1'b1;
        to_cyc(s + 101);
        sif.step_i = 1'b0;
        to_cyc(s + 213);
        chk("drop_bt3", 32'(sif.bt_o), 3);
        sif.run_i = 1'b0;
        to_cyc(s + 251);
        chk("drop_not_halted", 32'(sif.halted_o), 0);
        to_cyc(s + 252);
        chk("drop_halted", 32'(sif.halted_o), 1);
        chk("drop_bt0", 32'(sif.bt_o), 0);
        chk("drop_pa", 32'(sif.pa_o), 1);
        chk("drop_gnt_clear", 32'({sif.gnt_cpu_o, sif.gnt_dma_o}), 0);
        sif.cpu_req_i = 1'b0;
        sif.dma_req_i = 1'b0;

        // Single step from HALT.
        to_cyc(s + 257);
        sif.step_i = 1'b1;
        s2 = cyc + 1;
        tbc_q.push_back(s2 + 13);
        tbc_q.push_back(s2 + 27);
        tbc_q.push_back(s2 + 41);
        push_we(s2 + 42, 1'b0, 1'b0);
        to_cyc(s2);
        sif.step_i = 1'b0;
        chk("step_start_halted", 32'(sif.halted_o), 0);
        to_cyc(s2 + 41);
        chk("step_last_bt", 32'(sif.bt_o), 13);
        chk("step_last_pc", 32'(sif.pc_o), 1);
        to_cyc(s2 + 42);
        chk("step_end_halted", 32'(sif.halted_o), 1);
        chk("step_end_bt", 32'(sif.bt_o), 0);
        chk("step_end_pa", 32'(sif.pa_o), 1);
        to_cyc(s2 + 60);
        chk("step_stays_halted", 32'(sif.halted_o), 1);
        chk("step_stays_bt", 32'(sif.bt_o), 0);

        // HOLD stall at end of PC, then reset in PB of the next word.
        sif.run_i     = 1'b1;
        sif.cpu_req_i = 1'b1;
        s3 = cyc + 1;
        tbc_q.push_back(s3 + 13);
        tbc_q.push_back(s3 + 27);
        tbc_q.push_back(s3 + 60);
        push_we(s3 + 47, 1'b0, 1'b0);
        to_cyc(s3 + 38);
        chk("hold_at_bt10", 32'(sif.bt_o), 10);
        chk("hold_at_pc", 32'(sif.pc_o), 1);
        sif.hold_i = 1'b1;
        for (int i = 41; i <= 46; i++) begin
            to_cyc(s3 + i);
            chk("hold_bt13", 32'(sif.bt_o), 13);
        end
        sif.hold_i = 1'b0;
        to_cyc(s3 + 47);
        chk("hold_wrap_bt", 32'(sif.bt_o), 0);
        chk("hold_wrap_pa", 32'(sif.pa_o), 1);
        chk("hold_next_gnt_cpu", 32'(sif.gnt_cpu_o), 1);
        to_cyc(s3 + 68);
        chk("rst_at_pb", 32'(sif.pb_o), 1);
        chk("rst_at_bt7", 32'(sif.bt_o), 7);
        rstn = 1'b0;
        to_cyc(s3 + 69);
        chk_reset_vals("midword_reset");
        rstn          = 1'b1;
        sif.run_i     = 1'b0;
        sif.cpu_req_i = 1'b0;
        to_cyc(s3 + 75);
        chk("post_reset_halted", 32'(sif.halted_o), 1);

        chk("tbc_events_left", tbc_q.size(), 0);
        chk("word_end_events_left", we_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
